// File: rtl/vmem_dma_initiator.sv
// vmem_dma_initiator
// Single-channel DMA master for one vmem_dat DMA port. A descriptor
// {dir, addr, stride, len} becomes a burst of {we, addr, data} requests.
// Writes take data from the wr_* stream. Read returns come back in order with
// a fixed latency and cannot be stalled. They land in a FIFO that is protected
// by a credit check, and the FIFO is presented as the rd_* stream.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/ready, cmd_dir, cmd_addr, cmd_stride, cmd_len
//                                 descriptor handshake (dir 1 = write vmem)
//   wr_dat/valid/ready            write data stream in
//   rd_dat/valid/ready            read data stream out (FIFO head)
//   t_idma_dat/idma_valid/ready   {we, addr, data} request to vmem
//   i_odma_dat/odma_valid         read return from vmem
//   busy, done, err               status; done is a one-cycle pulse
//
// Optional feature macro: VMEM_DMA_ERR_EN. When it is defined, err is sticky
// and flags two cases: a return arriving with nothing outstanding, and a push
// into a full FIFO. When it is undefined, err is tied to 0.
module vmem_dma_initiator #(
    parameter int DATA_W      = 32,
    parameter int IADDR_W     = 16,
    parameter int LEN_W       = 16,
    parameter int RFIFO_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_dir,
    input  logic [IADDR_W-1:0]         cmd_addr,
    input  logic [IADDR_W-1:0]         cmd_stride,
    input  logic [LEN_W-1:0]           cmd_len,
    input  logic [DATA_W-1:0]          wr_dat,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [DATA_W-1:0]          rd_dat,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [IADDR_W+DATA_W:0]    t_idma_dat,
    output logic                       idma_valid,
    input  logic                       idma_ready,
    input  logic [DATA_W-1:0]          i_odma_dat,
    input  logic                       odma_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam int PTR_W = $clog2(RFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [IADDR_W-1:0] addr_q, addr_d, stride_q, stride_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   outs_q, outs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [DATA_W-1:0]  mem_q [RFIFO_DEPTH];

    logic cmd_hs, rd_hs, push, pop, full, ret_dec, credit_ok;
    logic [CNT_W:0] credit_use;

    // A read request is issued only when the FIFO is sure to have room for
    // it. That means every word already in flight plus every word buffered
    // must fit, so a return, which cannot be stalled, never finds the FIFO full.
    assign credit_use = {1'b0, outs_q} + {1'b0, cnt_q};
    assign credit_ok  = credit_use < (CNT_W+1)'(RFIFO_DEPTH);

    assign full     = (cnt_q == CNT_W'(RFIFO_DEPTH));
    assign push     = odma_valid && !full;
    assign rd_valid = (cnt_q != '0);
    assign pop      = rd_valid && rd_ready;
    assign rd_dat   = mem_q[rptr_q];
    assign busy     = (state_q != S_IDLE);
    // Saturate so that a stray return does not wrap the outstanding count.
    assign ret_dec  = odma_valid && (outs_q != '0);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        rem_d      = rem_q;
        cmd_ready  = 1'b0;
        idma_valid = 1'b0;
        t_idma_dat = '0;
        wr_ready   = 1'b0;
        done       = 1'b0;
        cmd_hs     = 1'b0;
        rd_hs      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_hs   = 1'b1;
                    addr_d   = cmd_addr;
                    stride_d = cmd_stride;
                    rem_d    = cmd_len;
                    if (cmd_len == '0) state_d = S_DONE;
                    else if (cmd_dir)  state_d = S_WR;
                    else               state_d = S_RD;
                end
            end
            S_WR: begin
                // The request is a direct view of the stream, so the request
                // stays stable exactly as long as the source holds its word.
                idma_valid = wr_valid;
                t_idma_dat = {1'b1, addr_q, wr_dat};
                wr_ready   = idma_ready;
                if (wr_valid && idma_ready) begin
                    addr_d = addr_q + stride_q;
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = S_DONE;
                end
            end
            S_RD: begin
                // Only registered terms go into valid. This keeps a
                // combinational idma_ready from looping back into it.
                idma_valid = (rem_q != '0) && credit_ok;
                t_idma_dat = {1'b0, addr_q, {DATA_W{1'b0}}};
                if (idma_valid && idma_ready) begin
                    rd_hs  = 1'b1;
                    addr_d = addr_q + stride_q;
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (outs_q == '0) state_d = S_DONE;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        outs_d = outs_q;
        case ({rd_hs, ret_dec})
            2'b10:   outs_d = outs_q + CNT_W'(1);
            2'b01:   outs_d = outs_q - CNT_W'(1);
            default: outs_d = outs_q;
        endcase
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            outs_q   <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            rem_q    <= rem_d;
            outs_q   <= outs_d;
            cnt_q    <= cnt_d;
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset. Pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= i_odma_dat;
    end

`ifdef VMEM_DMA_ERR_EN
    logic err_q, err_d;

    // When a new descriptor is accepted in the same cycle as an error, the
    // error wins.
    always_comb begin
        err_d = err_q;
        if (cmd_hs) err_d = 1'b0;
        if (odma_valid && ((outs_q == '0) || full)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vmem_dma_initiator.sv
module tb_vmem_dma_initiator;
    localparam int DW = 32, AW = 16, LW = 16, DEPTH = 16, LAT = 5;
`ifdef VMEM_DMA_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0, reset;
    logic          cmd_valid, cmd_ready, cmd_dir;
    logic [AW-1:0] cmd_addr, cmd_stride;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] wr_dat, rd_dat, i_odma_dat;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW+DW:0] t_idma_dat;
    logic          idma_valid, idma_ready, odma_valid, busy, done, err;

    always #5 clk = ~clk;

    vmem_dma_initiator #(.DATA_W(DW), .IADDR_W(AW), .LEN_W(LW), .RFIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_addr(cmd_addr), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
        .wr_dat(wr_dat), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_dat(rd_dat), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .t_idma_dat(t_idma_dat), .idma_valid(idma_valid), .idma_ready(idma_ready),
        .i_odma_dat(i_odma_dat), .odma_valid(odma_valid),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct { int due; logic [DW-1:0] d; } ret_t;
    typedef struct {
        bit dir; logic [AW-1:0] addr; logic [AW-1:0] stride; int len;
        int rdy; bit rdr; logic [DW-1:0] wb; logic [AW-1:0] last;
    } vec_t;

    int checks = 0, failures = 0, cyc = 0;
    ret_t          ret_q[$];
    logic [DW-1:0] fq[$], wrq[$];
    logic [DW-1:0] vmem [0:65535];
    logic [AW+DW:0] reqs[$];
    int done_n, done_cyc, cmd_cyc, first_v_cyc, last_hs_cyc, last_ret_cyc, pop_n, pop_start;
    bit hold_pend, wr_cons, rd_en, rd_rand, wr_rand, err_exp, spur;
    logic [AW+DW:0] hold_dat;
    int rdy_mode, pat_i;
    logic [3:0] rdy_pat = 4'b1001;
    bit d_dir; logic [AW-1:0] d_addr, d_stride; int d_len; logic [DW-1:0] d_wb;
    vec_t vecs[10];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_idma_valid"}, 64'(idma_valid), 64'(0));
        chk({tag, "_wr_ready"}, 64'(wr_ready), 64'(0));
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
        chk({tag, "_t_idma_dat"}, 64'(t_idma_dat), 64'(0));
    endtask

    // Sampled mid-cycle: records what the next rising edge will commit.
    task automatic observe();
        logic [AW-1:0] a;
        if (reset) begin hold_pend = 0; return; end
        if (hold_pend) begin
            chk("hold_valid", 64'(idma_valid), 64'(1));
            chk("hold_dat", 64'(t_idma_dat), 64'(hold_dat));
        end
        chk("err", 64'(err), 64'(err_exp));
        chk("busy", 64'(busy), 64'(!cmd_ready));
        if (idma_valid && t_idma_dat[AW+DW]) chk("wr_ready_mirror", 64'(wr_ready), 64'(idma_ready));
        if (idma_valid && first_v_cyc < 0) first_v_cyc = cyc;
        if (idma_valid && idma_ready) begin
            a = t_idma_dat[AW+DW-1:DW];
            reqs.push_back(t_idma_dat);
            last_hs_cyc = cyc;
            if (t_idma_dat[AW+DW]) vmem[a] = t_idma_dat[DW-1:0];
            else ret_q.push_back('{cyc + LAT, vmem[a]});
        end
        wr_cons = wr_valid && wr_ready;
        if (wr_cons && wrq.size() > 0) void'(wrq.pop_front());
        chk("rd_valid", 64'(rd_valid), 64'(fq.size() > 0));
        if (rd_valid && rd_ready && fq.size() > 0) begin
            chk("rd_dat", 64'(rd_dat), 64'(fq[0]));
            void'(fq.pop_front());
            pop_n++;
        end
        if (cmd_valid && cmd_ready) begin cmd_cyc = cyc; err_exp = 0; end
        if (odma_valid) begin
            fq.push_back(i_odma_dat);
            last_ret_cyc = cyc;
            if (spur) err_exp = ERR_EN;
        end
        if (done) begin done_n++; done_cyc = cyc; end
        hold_pend = idma_valid && !idma_ready;
        hold_dat  = t_idma_dat;
    endtask

    task automatic drive();
        odma_valid = 1'b0; i_odma_dat = '0; spur = 0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            odma_valid = 1'b1; i_odma_dat = ret_q[0].d;
            void'(ret_q.pop_front());
        end
        case (rdy_mode)
            0:       idma_ready = 1'b1;
            1:       idma_ready = 1'($urandom_range(0, 1));
            default: begin idma_ready = rdy_pat[pat_i % 4]; pat_i++; end
        endcase
        rd_ready = rd_en && (!rd_rand || ($urandom_range(0, 1) == 1));
        if (!(wr_valid && !wr_cons)) begin
            wr_valid = (wrq.size() > 0) && (!wr_rand || $urandom_range(0, 2) != 0);
            wr_dat   = (wrq.size() > 0) ? wrq[0] : '0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk); #1;
        cyc++;
        drive();
    endtask

    task automatic start_desc(bit dir, logic [AW-1:0] a, logic [AW-1:0] s, int len, logic [DW-1:0] wb);
        int n = 0;
        d_dir = dir; d_addr = a; d_stride = s; d_len = len; d_wb = wb;
        while (!cmd_ready && n < 500) begin cycle(); n++; end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        reqs.delete(); done_n = 0; done_cyc = -1; first_v_cyc = -1; pop_start = pop_n;
        if (dir) for (int k = 0; k < len; k++) wrq.push_back(wb + DW'(k));
        cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = a; cmd_stride = s; cmd_len = LW'(len);
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_desc(bit chk_last, logic [AW-1:0] exp_last, bit chk_first);
        int n = 0;
        logic [AW-1:0] ea;
        while (done_n == 0 && n < 4000) begin cycle(); n++; end
        chk("done_seen", 64'(done_n), 64'(1));
        repeat (3) cycle();
        chk("done_once", 64'(done_n), 64'(1));
        chk("req_count", 64'(reqs.size()), 64'(d_len));
        for (int k = 0; k < reqs.size() && k < d_len; k++) begin
            ea = AW'(int'(d_addr) + k * int'(d_stride));
            chk("req_we", 64'(reqs[k][AW+DW]), 64'(d_dir));
            chk("req_addr", 64'(reqs[k][AW+DW-1:DW]), 64'(ea));
            chk("req_data", 64'(reqs[k][DW-1:0]), d_dir ? 64'(d_wb + DW'(k)) : 64'(0));
        end
        if (chk_last && d_len > 0 && reqs.size() >= d_len)
            chk("last_addr", 64'(reqs[d_len-1][AW+DW-1:DW]), 64'(exp_last));
        if (d_len == 0) begin
            chk("zero_len_done", 64'(done_cyc), 64'(cmd_cyc + 1));
            chk("zero_len_novalid", 64'(first_v_cyc), 64'(-1));
        end else if (d_dir) begin
            chk("wr_done_lat", 64'(done_cyc), 64'(last_hs_cyc + 1));
        end else begin
            chk("rd_done_after_ret", 64'(done_cyc - last_ret_cyc >= 1 && done_cyc - last_ret_cyc <= 2), 64'(1));
        end
        if (chk_first && d_len > 0) chk("first_req_lat", 64'(first_v_cyc), 64'(cmd_cyc + 1));
        rd_en = 1; n = 0;
        while (fq.size() > 0 && n < 2000) begin cycle(); n++; end
        chk("fifo_drained", 64'(fq.size()), 64'(0));
        if (!d_dir) chk("rd_words", 64'(pop_n - pop_start), 64'(d_len));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 16'h0010, 16'h0001, 8,  0, 1'b0, 32'h000000A0, 16'h0017};
        vecs[1] = '{1'b1, 16'h0100, 16'h0003, 6,  2, 1'b0, 32'h00000B00, 16'h010F};
        vecs[2] = '{1'b1, 16'hFFFE, 16'h0001, 4,  0, 1'b0, 32'h00000C00, 16'h0001};
        vecs[3] = '{1'b0, 16'hFFFE, 16'h0001, 4,  0, 1'b0, 32'h0,        16'h0001};
        vecs[4] = '{1'b1, 16'h0000, 16'h0000, 3,  1, 1'b0, 32'h00000D00, 16'h0000};
        vecs[5] = '{1'b0, 16'h0030, 16'h0000, 5,  1, 1'b1, 32'h0,        16'h0030};
        vecs[6] = '{1'b1, 16'h1234, 16'h0001, 0,  0, 1'b0, 32'h0,        16'h0000};
        vecs[7] = '{1'b0, 16'h1234, 16'h0001, 0,  0, 1'b0, 32'h0,        16'h0000};
        vecs[8] = '{1'b0, 16'h8000, 16'h4000, 5,  1, 1'b0, 32'h0,        16'h8000};
        vecs[9] = '{1'b0, 16'h0020, 16'h0010, 20, 1, 1'b1, 32'h0,        16'h0150};
        for (int i = 0; i < 65536; i++) vmem[i] = $urandom;

        reset = 1; cmd_valid = 0; cmd_dir = 0; cmd_addr = '0; cmd_stride = '0; cmd_len = '0;
        wr_dat = '0; wr_valid = 0; rd_ready = 0; idma_ready = 0; i_odma_dat = '0; odma_valid = 0;
        rdy_mode = 0; rd_en = 1; rd_rand = 0; wr_rand = 0; pat_i = 0; pop_n = 0;
        err_exp = 0; spur = 0; hold_pend = 0; wr_cons = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("por");
        @(posedge clk); #1;
        reset = 0;
        drive();

        // Directed table: bursts, backpressure, wrap, stride 0, zero length.
        foreach (vecs[i]) begin
            rdy_mode = vecs[i].rdy; rd_rand = vecs[i].rdr; wr_rand = 0; rd_en = 1; pat_i = 0;
            start_desc(vecs[i].dir, vecs[i].addr, vecs[i].stride, vecs[i].len, vecs[i].wb);
            finish_desc(1'b1, vecs[i].last, 1'b1);
        end

        // Credit limit: with the consumer stalled, only DEPTH reads may issue.
        rdy_mode = 0; rd_rand = 0; rd_en = 0;
        start_desc(1'b0, 16'h0020, 16'h0010, 20, '0);
        repeat (40) cycle();
        chk("credit_reqs", 64'(reqs.size()), 64'(DEPTH));
        chk("credit_stall", 64'(idma_valid), 64'(0));
        rd_en = 1;
        finish_desc(1'b1, 16'h0150, 1'b1);

        // Reset with reads in flight; the vmem model is reset along with it.
        rd_en = 0;
        start_desc(1'b0, 16'h0040, 16'h0001, 20, '0);
        repeat (8) cycle();
        reset = 1; ret_q.delete(); fq.delete(); wrq.delete();
        odma_valid = 0; wr_valid = 0; err_exp = 0;
        cycle();
        reset = 0;
        @(negedge clk);
        chk_reset_vals("mid");
        @(posedge clk); #1; cyc++; drive();
        rd_en = 1;
        start_desc(1'b1, 16'h0200, 16'h0002, 5, 32'h00000E00);
        finish_desc(1'b1, 16'h0208, 1'b1);

        // Randomized descriptors against the model.
        for (int t = 0; t < 15; t++) begin
            logic [AW-1:0] ra, rs;
            rdy_mode = 1; rd_rand = 1; wr_rand = 1; rd_en = 1;
            ra = AW'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 2));
            start_desc(1'($urandom_range(0, 1)), ra, rs, $urandom_range(0, 24), $urandom);
            finish_desc(1'b0, '0, 1'b0);
        end

        // Stray return while idle: err behaviour, then cleared by a new descriptor.
        rdy_mode = 0; rd_rand = 0; wr_rand = 0; rd_en = 1;
        odma_valid = 1; i_odma_dat = 32'hDEADBEEF; spur = 1;
        cycle();
        cycle();
        chk("err_set", 64'(err), 64'(ERR_EN));
        repeat (3) cycle();
        chk("err_sticky", 64'(err), 64'(ERR_EN));
        start_desc(1'b1, 16'h0300, 16'h0001, 2, 32'h00000F00);
        chk("err_clear", 64'(err), 64'(0));
        finish_desc(1'b1, 16'h0301, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vmem_dma_initiator.md
Name: vmem_dma_initiator

Overview:
- Single DMA channel master that drives one vmem_dat DMA port (t_idma_N_dat / idma_valid / idma_ready / i_odma_N_dat / odma_valid).
- Accepts a descriptor (direction, start address, stride, length) and turns it into a burst of {we, addr, data} requests.
- Writes take data from a streaming source. Reads collect the in-order, fixed-latency return data into a credit-protected FIFO and present it as a stream.
- Sits between the host/sequencer DMA layer and the vector memory. Four instances, one per vmem DMA port.

Parameters:
- DATA_W, 32, data word width; equals vmem dataWidth.
- IADDR_W, 16, request address width; low 4 bits select bank, upper bits select row.
- LEN_W, 16, descriptor length field width (words).
- RFIFO_DEPTH, 16, read-return FIFO depth; power of two, at least 4.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, descriptor valid.
- cmd_ready, out, 1, high only in IDLE.
- cmd_dir, in, 1, 1 = write to vmem, 0 = read from vmem.
- cmd_addr, in, IADDR_W, start address.
- cmd_stride, in, IADDR_W, per-word address increment.
- cmd_len, in, LEN_W, word count; 0 is legal.
- wr_dat, in, DATA_W, write stream data.
- wr_valid, in, 1, write stream valid.
- wr_ready, out, 1, write stream ready.
- rd_dat, out, DATA_W, read stream data (FIFO head).
- rd_valid, out, 1, FIFO not empty.
- rd_ready, in, 1, read stream ready.
- t_idma_dat, out, IADDR_W+DATA_W+1, {we, addr, data} to vmem.
- idma_valid, out, 1, request valid.
- idma_ready, in, 1, vmem accepts request.
- i_odma_dat, in, DATA_W, read return data.
- odma_valid, in, 1, read return valid; cannot be back-pressured.
- busy, out, 1, state != IDLE.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, sticky protocol error (see Optional Feature).

Behaviour:
- Reset: state=IDLE; addr, remaining count, outstanding count, FIFO pointers = 0. Outputs after reset: cmd_ready=1, busy=0, done=0, err=0, idma_valid=0, wr_ready=0, rd_valid=0, t_idma_dat=0.
- Handshakes: every transfer happens on valid&&ready in the same cycle. Once asserted, idma_valid and t_idma_dat must hold until accepted. idma_ready may depend combinationally on idma_valid and the address, so the block must not create a loop from idma_ready back to idma_valid.
- IDLE: on cmd_valid, latch the descriptor. Next state:
  - cmd_len==0: go to DONE.
  - cmd_dir=1: go to WR.
  - cmd_dir=0: go to RD.
- WR state:
  - idma_valid=wr_valid; t_idma_dat={1'b1, addr, wr_dat}; wr_ready=idma_ready.
  - On each handshake: addr += stride (mod 2^IADDR_W), remaining -= 1.
  - Handshake on the last word: go to DONE.
- RD state:
  - idma_valid=1 while remaining>0 and (outstanding + fifo_count) < RFIFO_DEPTH (credit check); t_idma_dat={1'b0, addr, 0}.
  - On each handshake: outstanding += 1, addr += stride, remaining -= 1.
  - When remaining reaches 0: go to DRAIN.
- Returns (any state): odma_valid pushes i_odma_dat into the FIFO and decrements outstanding. If a read handshake and a return happen in the same cycle, outstanding is unchanged.
- DRAIN: wait until outstanding==0, then go to DONE. The FIFO does not need to be empty.
- DONE: done=1 for exactly one cycle; next state is IDLE.
- FIFO:
  - rd_valid = !empty; pop on rd_valid&&rd_ready.
  - Simultaneous push and pop: count unchanged, data order preserved.
  - The FIFO continues to drain in IDLE and across later descriptors.
  - The credit check guarantees no overflow.
- Wrap-around: address wraps modulo 2^IADDR_W. stride=0 repeats the same address.
- Latency:
  - First request is issued the cycle after the descriptor handshake.
  - A return appears on rd_valid the cycle after odma_valid.
- Reset mid-operation: returns to the reset state and discards FIFO contents. The vmem shares the same reset, so no returns arrive after reset.

Optional Feature:
- Macro: VMEM_DMA_ERR_EN.
- Defined: err becomes sticky 1 on:
  - odma_valid while outstanding==0, or
  - a push to a full FIFO (the push is dropped).
  err clears only on reset or on acceptance of a new descriptor.
- Undefined: err is tied to 0 and the checking logic is removed; an unexpected return is pushed if the FIFO has room, otherwise dropped.

Test Plan:
- Write burst, cmd_addr=0x0010, stride=1, len=8, wr_dat 0xA0..0xA7, idma_ready=1 -> eight requests: we=1, addr 0x0010..0x0017, data 0xA0..0xA7; done pulses once, the cycle after the 8th handshake.
- Read burst, addr=0x0020, stride=16, len=20, vmem model with latency 5, rd_ready=0 -> at most 16 requests issue, then idma_valid drops. Release rd_ready -> all 20 words delivered in order, done asserted after the 20th return.
- Backpressure: idma_ready toggles 1,0,0,1 during a write -> idma_valid and t_idma_dat held stable while ready=0; wr_ready mirrors idma_ready; no lost or duplicated words.
- Wrap and zero length: addr=0xFFFE, stride=1, len=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001. Then len=0 -> done the cycle after IDLE is left, no idma_valid.
- Reset with reads outstanding (vmem reset together) -> the next cycle shows all reset values, rd_valid=0, and a new descriptor is accepted normally.
- With VMEM_DMA_ERR_EN: odma_valid asserted in IDLE -> err=1 and stays 1; the next cmd handshake clears it to 0.
